// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared types and constants for the message sequencer
// Contents:
//   state_e          sequencer FSM states
//   MSG_LEN_DEFAULT  ROM entries sent per message
//   MSG_ADDR_W       ROM address width
//   CHAR_LF/CHAR_CR  line terminator bytes held in the last two ROM entries
package msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT_TX,
        SEND,
        HOLD
    } state_e;

    localparam int          MSG_LEN_DEFAULT = 10;
    localparam int          MSG_ADDR_W      = 4;
    localparam logic [7:0]  CHAR_LF         = 8'h0A;
    localparam logic [7:0]  CHAR_CR         = 8'h0D;

endpackage

// File: rtl/message_sequencer.sv
// rtl/message_sequencer.sv - streams one ROM message byte-by-byte to a UART transmitter
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         request one message (sampled only in IDLE)
//   rom_addr      ROM address (registered, equals the byte index)
//   rom_data      ROM read data, one cycle after rom_addr
//   tx_data       byte to transmit (registered, holds between strobes)
//   new_tx_data   one-cycle strobe, tx_data valid
//   tx_busy       transmitter busy, rises the cycle after new_tx_data
//   busy          high in every non-IDLE state
//   done          one-cycle pulse in the first IDLE cycle after the last byte
module message_sequencer
    import msg_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int ADDR_W  = MSG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        tx_data_q;
    logic              new_tx_q;
    logic              busy_q;
    logic              done_q;

    // All outputs are registered and updated alongside the state, so busy,
    // new_tx_data and done line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
            new_tx_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            new_tx_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                // rom_addr has been stable for this whole cycle; the ROM
                // registers rom[idx] at the closing edge.
                FETCH: state_q <= LATCH;
                LATCH: begin
                    tx_data_q <= rom_data;
                    state_q   <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        state_q  <= SEND;
                        new_tx_q <= 1'b1;
                    end
                end
                SEND: state_q <= HOLD;
                // Guard cycle: tx_busy only rises the cycle after the strobe,
                // so it must not be sampled before the next WAIT_TX.
                HOLD: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = idx_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_message_sequencer.sv
// tb/tb_message_sequencer.sv - self-checking bench for message_sequencer
module tb_message_sequencer;
    import msg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic       done;

    message_sequencer #(.MSG_LEN(10), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [63:0] rom_bits = 64'h48454C4C4F202020;
    int          bp_len = 0;
    int          bp_cnt = 0;
    bit          prev_strobe = 1'b0;

    int          s_cyc[$];
    logic [7:0]  s_dat[$];
    int          d_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Message ROM: registered output, one-cycle latency, space when out of range.
    always @(posedge clk) begin
        if (rom_addr < 4'd8)       rom_data <= rom_bits[63 - 8*rom_addr -: 8];
        else if (rom_addr == 4'd8) rom_data <= CHAR_LF;
        else if (rom_addr == 4'd9) rom_data <= CHAR_CR;
        else                       rom_data <= 8'h20;
    end

    // Monitor plus transmitter model: tx_busy rises the cycle after a strobe
    // and stays high for bp_len cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (new_tx_data) begin
                s_cyc.push_back(cyc);
                s_dat.push_back(tx_data);
                if (tx_busy || !busy) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL strobe_cond: tx_busy=%0b busy=%0b at cycle %0d, required tx_busy=0 busy=1",
                             tx_busy, busy, cyc);
                end
            end
            if (done) d_cyc.push_back(cyc);
            if (rom_addr > 4'd9) begin
                vectors++;
                miscompares++;
                $display("FAIL addr_range: rom_addr=%0d, required <= 9", rom_addr);
            end
        end
        if (prev_strobe && bp_len > 0) bp_cnt = bp_len;
        else if (bp_cnt > 0)           bp_cnt = bp_cnt - 1;
        tx_busy     = (bp_cnt != 0);
        prev_strobe = new_tx_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] bits, input int i);
        logic [7:0] msg [10];
        for (int k = 0; k < 8; k++) msg[k] = bits[63 - 8*k -: 8];
        msg[8] = CHAR_LF;
        msg[9] = CHAR_CR;
        return msg[i];
    endfunction

    task automatic clear_mon();
        s_cyc.delete();
        s_dat.delete();
        d_cyc.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (tx_busy || busy); i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // Check the recorded strobes/dones against the message model.
    task automatic verify(input logic [63:0] bits, input int bp, input int nmsg, input int c0);
        check("strobe_count", s_cyc.size(), 10 * nmsg);
        check("done_count", d_cyc.size(), nmsg);
        for (int k = 0; k < s_dat.size() && k < 10 * nmsg; k++)
            check($sformatf("byte%0d", k), s_dat[k], exp_byte(bits, k % 10));
        if (s_cyc.size() > 0 && bp == 0) check("first_latency", s_cyc[0] - c0, 4);
        for (int k = 1; k < s_cyc.size() && k < 10 * nmsg; k++) begin
            if (bp == 0)
                check($sformatf("gap%0d", k), s_cyc[k] - s_cyc[k-1], (k % 10 == 0) ? 6 : 5);
            else if (s_cyc[k] - s_cyc[k-1] < bp + 1)
                check($sformatf("bp_gap%0d", k), s_cyc[k] - s_cyc[k-1], bp + 1);
            else
                vectors++;
        end
        for (int m = 0; m < d_cyc.size() && s_cyc.size() >= 10 * (m + 1); m++)
            check($sformatf("done_time%0d", m), d_cyc[m] - s_cyc[10*m + 9], 2);
    endtask

    task automatic run_case(input logic [63:0] bits, input int bp, input bit hold, input int nmsg);
        int c0;
        int budget;
        rom_bits = bits;
        bp_len   = bp;
        clear_mon();
        budget = nmsg * 10 * (bp + 8) + 60;
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end else begin
            for (int i = 0; i < budget && s_cyc.size() < 10 * nmsg; i++) @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < budget && d_cyc.size() < nmsg; i++) @(negedge clk);
        if (d_cyc.size() < nmsg) check("timeout_done", d_cyc.size(), nmsg);
        repeat (10) @(negedge clk);
        verify(bits, bp, nmsg, c0);
        wait_idle();
    endtask

    typedef struct {
        logic [63:0] bits;
        int          bp;
        bit          hold;
        int          nmsg;
    } vec_t;

    vec_t tbl [4];
    bit   busy_seen;
    int   c0;

    initial begin
        tbl[0] = '{64'h48454C4C4F202020, 0,  1'b0, 1};
        tbl[1] = '{64'h48454C4C4F202020, 20, 1'b0, 1};
        tbl[2] = '{64'h48454C4C4F202020, 0,  1'b1, 3};
        tbl[3] = '{64'h0001FF7E80AA5500, 3,  1'b0, 1};

        // Reset values, then start held low keeps busy at 0.
        repeat (2) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_new_tx_data", new_tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        busy_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check("idle_no_busy", busy_seen, 0);

        for (int v = 0; v < 4; v++) run_case(tbl[v].bits, tbl[v].bp, tbl[v].hold, tbl[v].nmsg);

        // Start pulses during bytes 3 and 7 are ignored.
        rom_bits = 64'h48454C4C4F202020;
        bp_len = 0;
        clear_mon();
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && s_cyc.size() < 3; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && s_cyc.size() < 7; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && d_cyc.size() < 1; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        verify(64'h48454C4C4F202020, 0, 1, c0);
        wait_idle();

        // Asynchronous abort in the cycle after the 3rd strobe.
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && s_cyc.size() < 3; i++) @(negedge clk);
        check("abort_reached", s_cyc.size(), 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rom_addr", rom_addr, 0);
        check("abort_tx_data", tx_data, 0);
        check("abort_new_tx", new_tx_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_case(64'h48454C4C4F202020, 0, 1'b0, 1);

        // Random ROM contents and backpressure lengths.
        for (int r = 0; r < 6; r++) begin
            logic [63:0] rb;
            rb = {$urandom, $urandom};
            run_case(rb, $urandom_range(0, 25), r[0], r[0] ? 2 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
